// File: rtl/admo_div.sv
// Iterative RV32M divide/remainder unit (DIV, DIVU, REM, REMU).
// Restoring shift-subtract, one quotient bit per cycle, registered result with a one-cycle valid pulse.
module admo_div #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  start_i,
   input  logic                  flush_i,
   input  logic [1:0]            op_i,
   input  logic [DATA_WIDTH-1:0] operand_a_i,
   input  logic [DATA_WIDTH-1:0] operand_b_i,
   output logic                  busy_o,
   output logic                  valid_o,
   output logic [DATA_WIDTH-1:0] result_o
);

   localparam int CW = $clog2(DATA_WIDTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [1:0]            op_q;
   logic                  sign_a_q, sign_b_q;
   logic [DATA_WIDTH-1:0] quo_q, div_q, rem_q, result_q;
   logic [CW-1:0]         cnt_q;

   logic                  accept, is_signed, sign_a, sign_b, b_zero, ovf, special;
   logic [DATA_WIDTH-1:0] abs_a, abs_b, special_res, quo_step, rem_step, calc_res;
   logic [DATA_WIDTH:0]   rem_shift, diff;

   // Operand conditioning and special-case decode for the accept edge.
   always_comb begin
      accept      = (state_q == IDLE) && start_i && !flush_i;
      is_signed   = ~op_i[0];
      sign_a      = is_signed & operand_a_i[DATA_WIDTH-1];
      sign_b      = is_signed & operand_b_i[DATA_WIDTH-1];
      abs_a       = sign_a ? -operand_a_i : operand_a_i;
      abs_b       = sign_b ? -operand_b_i : operand_b_i;
      b_zero      = (operand_b_i == '0);
      ovf         = is_signed && (operand_a_i == {1'b1, {(DATA_WIDTH-1){1'b0}}})
                    && (operand_b_i == '1);
      special     = b_zero | ovf;
      // Zero divisor wins over signed overflow.
      if (b_zero) special_res = op_i[1] ? operand_a_i : '1;
      else        special_res = op_i[1] ? '0 : operand_a_i;
   end

   // One restoring iteration: the trial subtract is one bit wider so its MSB is the borrow.
   always_comb begin
      rem_shift = {rem_q, quo_q[DATA_WIDTH-1]};
      diff      = rem_shift - {1'b0, div_q};
      if (!diff[DATA_WIDTH]) begin
         rem_step = diff[DATA_WIDTH-1:0];
         quo_step = {quo_q[DATA_WIDTH-2:0], 1'b1};
      end else begin
         rem_step = rem_shift[DATA_WIDTH-1:0];
         quo_step = {quo_q[DATA_WIDTH-2:0], 1'b0};
      end
      case (op_q)
         2'b00:   calc_res = (sign_a_q ^ sign_b_q) ? -quo_step : quo_step;
         2'b01:   calc_res = quo_step;
         2'b10:   calc_res = sign_a_q ? -rem_step : rem_step;
         default: calc_res = rem_step;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   // NOTE: next state gets its default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start_i) state_d = special ? DONE : CALC;
         CALC:    if (cnt_q == '0) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (flush_i) state_d = IDLE;
   end

   // NOTE: reset is synchronous and clears every working register, not just the control state.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         op_q     <= '0;
         sign_a_q <= 1'b0;
         sign_b_q <= 1'b0;
         quo_q    <= '0;
         div_q    <= '0;
         rem_q    <= '0;
         cnt_q    <= '0;
         result_q <= '0;
      end else if (accept) begin
         op_q     <= op_i;
         sign_a_q <= sign_a;
         sign_b_q <= sign_b;
         quo_q    <= abs_a;
         div_q    <= abs_b;
         rem_q    <= '0;
         cnt_q    <= CW'(DATA_WIDTH-1);
         if (special) result_q <= special_res;
      end else if (state_q == CALC && !flush_i) begin
         quo_q <= quo_step;
         rem_q <= rem_step;
         cnt_q <= cnt_q - 1'b1;
         if (cnt_q == '0) result_q <= calc_res;
      end
   end

   assign busy_o   = (state_q != IDLE);
   assign valid_o  = (state_q == DONE);
   assign result_o = result_q;

endmodule

// File: tb/tb_admo_div.sv
// Self-checking bench for admo_div: directed vector table, randomized ops against an
// arithmetic reference model, and hand-written flush / overlap / reset sequences.
module tb_admo_div;

   localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        flush = 1'b0;
   logic [1:0]  op = '0;
   logic [31:0] opa = '0, opb = '0;
   logic        busy, valid;
   logic [31:0] result;

   int vectors = 0;
   int miscompares = 0;
   logic [31:0] last_exp = '0;

   admo_div dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .start_i     (start),
      .flush_i     (flush),
      .op_i        (op),
      .operand_a_i (opa),
      .operand_b_i (opb),
      .busy_o      (busy),
      .valid_o     (valid),
      .result_o    (result)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          busy;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Reference model: plain 64-bit arithmetic with RISC-V special cases.
   function automatic logic [31:0] ref_result(input logic [1:0] o, input logic [31:0] a,
                                              input logic [31:0] b);
      longint sa, sb, ua, ub;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'd0, a});
      ub = longint'({32'd0, b});
      if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
      case (o)
         OP_DIV:  return 32'(sa / sb);
         OP_DIVU: return 32'(ua / ub);
         OP_REM:  return 32'(sa % sb);
         default: return 32'(ua % ub);
      endcase
   endfunction

   function automatic int ref_busy(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      if (b == 32'd0) return 1;
      if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 33;
   endfunction

   // Issue one op from a non-edge instant, scramble operands after accept, watch until idle.
   task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int cycles, output int vcnt,
                         output int vidx);
      res = 'x; cycles = 0; vcnt = 0; vidx = 0;
      op = o; opa = a; opb = b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; opa = $urandom; opb = $urandom; op = 2'($urandom);
      while (busy && cycles < 200) begin
         cycles++;
         if (valid) begin vcnt++; vidx = cycles; res = result; end
         @(posedge clk); #1;
      end
   endtask

   task automatic run_and_check(input string tag, input logic [1:0] o, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] exp, input int exp_busy);
      logic [31:0] res;
      int cycles, vcnt, vidx;
      run_op(o, a, b, res, cycles, vcnt, vidx);
      check({tag, ".result"}, res, exp);
      check({tag, ".busy_cycles"}, 32'(cycles), 32'(exp_busy));
      check({tag, ".valid_count"}, 32'(vcnt), 32'd1);
      check({tag, ".valid_cycle"}, 32'(vidx), 32'(exp_busy));
      check({tag, ".idle_after"}, {31'd0, busy}, 32'd0);
      last_exp = exp;
   endtask

   vec_t vecs[13];

   initial begin
      logic [31:0] res, ra, rb;
      logic [1:0]  ro;
      int cycles, vcnt, vidx;

      vecs[0]  = '{OP_DIVU, 32'd100,        32'd7,          32'd14,         33};
      vecs[1]  = '{OP_REMU, 32'd100,        32'd7,          32'd2,          33};
      vecs[2]  = '{OP_DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  33};
      vecs[3]  = '{OP_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33};
      vecs[4]  = '{OP_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33};
      vecs[5]  = '{OP_REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          33};
      vecs[6]  = '{OP_DIV,  32'h8000_0000,  32'd2,          32'hC000_0000,  33};
      vecs[7]  = '{OP_DIVU, 32'd5,          32'd0,          32'hFFFF_FFFF,  1};
      vecs[8]  = '{OP_REMU, 32'd5,          32'd0,          32'd5,          1};
      vecs[9]  = '{OP_DIV,  32'hFFFF_FFFD,  32'd0,          32'hFFFF_FFFF,  1};
      vecs[10] = '{OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1};
      vecs[11] = '{OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1};
      vecs[12] = '{OP_DIV,  32'h8000_0000,  32'd0,          32'hFFFF_FFFF,  1};

      repeat (2) @(posedge clk);
      #1;
      check("reset.busy",   {31'd0, busy},  32'd0);
      check("reset.valid",  {31'd0, valid}, 32'd0);
      check("reset.result", result,         32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 13; i++)
         run_and_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                       vecs[i].exp, vecs[i].busy);

      for (int i = 0; i < 40; i++) begin
         ro = 2'($urandom);
         ra = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : 32'($urandom);
         case ($urandom_range(0, 9))
            0:       rb = 32'd0;
            1:       rb = 32'hFFFF_FFFF;
            2:       rb = 32'($urandom_range(1, 15));
            default: rb = 32'($urandom);
         endcase
         run_and_check($sformatf("rand%0d", i), ro, ra, rb, ref_result(ro, ra, rb),
                       ref_busy(ro, ra, rb));
      end

      // Flush on the 10th CALC edge with a coincident start that must be dropped.
      op = OP_DIVU; opa = 32'd1000; opb = 32'd3; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      check("flush.busy_before", {31'd0, busy}, 32'd1);
      flush = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; start = 1'b0;
      check("flush.busy",   {31'd0, busy},  32'd0);
      check("flush.valid",  {31'd0, valid}, 32'd0);
      check("flush.result", result,         last_exp);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check($sformatf("flush.quiet%0d", i), {30'd0, busy, valid}, 32'd0);
      end

      // DIVU 9/3 with start re-raised mid-operation and held through DONE.
      op = OP_DIVU; opa = 32'd9; opb = 32'd3; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cycles = 0; vcnt = 0; res = 'x;
      while (busy && cycles < 200) begin
         cycles++;
         if (valid) begin vcnt++; res = result; end
         if (cycles == 5) begin start = 1'b1; op = OP_DIVU; opa = 32'd100; opb = 32'd1; end
         @(posedge clk); #1;
      end
      start = 1'b0;
      check("overlap.result",      res,          32'd3);
      check("overlap.valid_count", 32'(vcnt),    32'd1);
      check("overlap.busy_cycles", 32'(cycles),  32'd33);
      @(posedge clk); #1;
      check("overlap.idle_after",  {31'd0, busy}, 32'd0);
      last_exp = 32'd3;

      // Synchronous reset mid-CALC.
      op = OP_DIVU; opa = 32'd1000; opb = 32'd7; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      check("midreset.busy",   {31'd0, busy},  32'd0);
      check("midreset.valid",  {31'd0, valid}, 32'd0);
      check("midreset.result", result,         32'd0);
      run_and_check("post_reset", OP_DIVU, 32'd8, 32'd2, 32'd4, 33);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
